// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types, constants and helpers for the radix-4 Booth
//                multiplier family.
//  Revision    : 1.1 - mode type and partial-product count helper added
// ============================================================================
package booth_pkg;

    // Legacy constants kept for existing fixed-width users.
    localparam int numbit  = 11;
    localparam int pp_deep = numbit / 2 + 1;

    // Per-transaction operand interpretation.
    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mult_mode_e;

    // Number of radix-4 Booth digits for an operand of the given width.
    function automatic int calc_pp_deep(input int width);
        return width / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_gen
//  Description : Radix-4 Booth partial-product generator. Takes operands
//                already extended to NUMBIT+2 bits and produces PP_DEEP
//                shifted, one's-complemented partial products plus the
//                +1 correction vector that completes each negation.
//  Revision    : 1.1 - parametrised width, signed/unsigned via extension
// ============================================================================
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter  int NUMBIT  = 11,
    localparam int PP_DEEP = calc_pp_deep(NUMBIT)
) (
    input  logic [NUMBIT+1:0]                  a_ext_i,
    input  logic [NUMBIT+1:0]                  b_ext_i,
    output logic [PP_DEEP-1:0][2*NUMBIT-1:0]   pp_o,
    output logic [2*NUMBIT-1:0]                corr_o
);
    localparam int EXT_W = NUMBIT + 2;
    localparam int PW    = 2 * NUMBIT;
    localparam int BP_W  = 2 * PP_DEEP + 1;

    // Multiplier with the implicit b[-1] = 0 appended at the bottom.
    logic [BP_W-1:0]    b_pad_w;
    logic [PW-1:0]      a1_w;
    logic [PW-1:0]      a2_w;
    logic [PP_DEEP-1:0] neg_w;

    // Extended operand is already correct for its mode; widen by its top bit.
    assign a1_w = {{(PW - EXT_W){a_ext_i[EXT_W-1]}}, a_ext_i};
    assign a2_w = a1_w << 1;

    // For odd widths the digits stop one bit short of the extended top bit,
    // which is only a repeat of the bit below it.
    if (BP_W == EXT_W + 1) begin : g_even
        assign b_pad_w = {b_ext_i, 1'b0};
    end else begin : g_odd
        logic unused_top_w;
        assign b_pad_w      = {b_ext_i[EXT_W-2:0], 1'b0};
        assign unused_top_w = b_ext_i[EXT_W-1];
    end

    for (genvar i = 0; i < PP_DEEP; i++) begin : g_pp
        logic [2:0]    trip_w;
        logic [PW-1:0] mag_w;

        assign trip_w = b_pad_w[2*i+2 -: 3];

        // Digit magnitude select: 0, A or 2A.
        always_comb begin
            mag_w = '0;
            case (trip_w)
                3'b001, 3'b010, 3'b101, 3'b110: mag_w = a1_w;
                3'b011, 3'b100:                 mag_w = a2_w;
                default:                        mag_w = '0;
            endcase
        end

        // Negative digits (100, 101, 110); 111 is a zero digit.
        assign neg_w[i] = trip_w[2] & ~(trip_w[1] & trip_w[0]);
        assign pp_o[i]  = (mag_w ^ {PW{neg_w[i]}}) << (2 * i);
    end

    // Each negated row needs +1 at its own weight to become two's complement.
    always_comb begin
        corr_o = '0;
        for (int k = 0; k < PP_DEEP; k++) begin
            corr_o[2*k] = neg_w[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_pipe
//  Description : Three-stage pipelined radix-4 Booth multiplier with a
//                valid/ready stream interface and per-transaction signed or
//                unsigned operands. S1 holds operands, S2 the carry-save
//                rows, S3 the final product. Back-pressure freezes all stages.
//  Revision    : 1.1 - pipelined, handshaked, signed/unsigned
// ============================================================================
module booth_mult_pipe
    import booth_pkg::*;
#(
    parameter  int NUMBIT  = 11,
    localparam int PP_DEEP = calc_pp_deep(NUMBIT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUMBIT-1:0]     in_a,
    input  logic [NUMBIT-1:0]     in_b,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUMBIT-1:0]   out_p
);
    localparam int EXT_W = NUMBIT + 2;
    localparam int PW    = 2 * NUMBIT;

    logic                       stall_w;
    logic                       advance_w;

    // S1: operands and mode
    logic                       v1_q;
    logic [NUMBIT-1:0]          a1_q;
    logic [NUMBIT-1:0]          b1_q;
    mult_mode_e                 mode1_q;

    logic                       sx_a_w;
    logic                       sx_b_w;
    logic [EXT_W-1:0]           a_ext_w;
    logic [EXT_W-1:0]           b_ext_w;
    logic [PP_DEEP-1:0][PW-1:0] pp_w;
    logic [PW-1:0]              corr_w;

    // S2: carry-save rows
    logic [PW-1:0]              csa_t_w;
    logic [PW-1:0]              sum_d;
    logic [PW-1:0]              carry_d;
    logic                       v2_q;
    logic [PW-1:0]              sum_q;
    logic [PW-1:0]              carry_q;

    // S3: product
    logic [PW-1:0]              p_d;
    logic                       v3_q;
    logic [PW-1:0]              p_q;

    // A held result blocks everything; bubbles are not squeezed out.
    assign stall_w   = v3_q & ~out_ready;
    assign advance_w = ~stall_w;
    assign in_ready  = advance_w;
    assign out_valid = v3_q;
    assign out_p     = p_q;

    // S1 capture: operands and their interpretation move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            mode1_q <= MODE_UNSIGNED;
        end else if (advance_w) begin
            v1_q    <= in_valid;
            a1_q    <= in_a;
            b1_q    <= in_b;
            mode1_q <= mult_mode_e'(in_signed);
        end
    end

    // Two extra bits let the Booth digits cover the full unsigned range.
    assign sx_a_w  = (mode1_q == MODE_SIGNED) & a1_q[NUMBIT-1];
    assign sx_b_w  = (mode1_q == MODE_SIGNED) & b1_q[NUMBIT-1];
    assign a_ext_w = {{2{sx_a_w}}, a1_q};
    assign b_ext_w = {{2{sx_b_w}}, b1_q};

    booth_pp_gen #(
        .NUMBIT (NUMBIT)
    ) u_pp_gen (
        .a_ext_i (a_ext_w),
        .b_ext_i (b_ext_w),
        .pp_o    (pp_w),
        .corr_o  (corr_w)
    );

    // 3:2 compression of all partial products and the correction vector.
    always_comb begin
        sum_d   = pp_w[0];
        carry_d = corr_w;
        csa_t_w = '0;
        for (int k = 1; k < PP_DEEP; k++) begin
            csa_t_w = sum_d ^ carry_d ^ pp_w[k];
            carry_d = ((sum_d & carry_d) | (sum_d & pp_w[k]) | (carry_d & pp_w[k])) << 1;
            sum_d   = csa_t_w;
        end
    end

    // S2 capture of the carry-save pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
        end else if (advance_w) begin
            v2_q    <= v1_q;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Final carry-propagate add; overflow past 2*NUMBIT bits is discarded.
    assign p_d = sum_q + carry_q;

    // S3 capture of the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q <= 1'b0;
            p_q  <= '0;
        end else if (advance_w) begin
            v3_q <= v2_q;
            p_q  <= p_d;
        end
    end

endmodule
`default_nettype wire
